// File: rtl/sdram_arbiter.sv
// Command scheduler for the shared 16-bit SDRAM port: arbitrates video refill,
// cache write-back and cache fill, and steers returning data beats.
module sdram_arbiter #(
  parameter int VID_BURSTS     = 19200,
  parameter int MAX_VID_STREAK = 4,
  parameter int VID_BEATS      = 16,
  parameter int LINE_BEATS     = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_low,
  input  logic        vid_sync,
  input  logic        c_wr_req,
  input  logic        c_rd_req,
  input  logic [16:0] c_waddr,
  input  logic [16:0] c_raddr,
  output logic [1:0]  sys_cmd,
  output logic [22:0] sys_addr,
  input  logic [1:0]  sys_cmd_ack,
  input  logic        sys_rd_data_valid,
  input  logic        sys_wr_data_valid,
  input  logic [15:0] sys_dout,
  output logic        cache_wr_data,
  output logic        cache_rd_data,
  output logic [31:0] vq_data,
  output logic        vq_we,
  output logic        busy
);

  localparam int MAX_BEATS = (VID_BEATS > LINE_BEATS) ? VID_BEATS : LINE_BEATS;
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
  localparam int STREAK_W  = $clog2(MAX_VID_STREAK + 1);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_STREAK);
  localparam logic [BEAT_W-1:0]   VID_LAST   = BEAT_W'(VID_BEATS - 1);
  localparam logic [BEAT_W-1:0]   LINE_LAST  = BEAT_W'(LINE_BEATS - 1);
  localparam logic [18:0]         PTR_LAST   = 19'(VID_BURSTS - 1);

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WR    = 2'b01;
  localparam logic [1:0] CMD_RD32  = 2'b10;
  localparam logic [1:0] CMD_RD256 = 2'b11;

  // state  | meaning
  // S_IDLE | no command outstanding, arbitrating requesters
  // S_CMD  | command presented, waiting for matching ack
  // S_XFER | counting data beats of the owner's strobe type
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_XFER} state_t;
  typedef enum logic [1:0] {OWN_VID, OWN_CW, OWN_CR} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [22:0]         addr_q, addr_d;
  logic [18:0]         ptr_q, ptr_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                resync_q, resync_d;
  logic                half_q, half_d;
  logic [15:0]         low_q, low_d;
  logic [31:0]         vq_data_q, vq_data_d;
  logic                vq_we_q, vq_we_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  logic        cache_pend;
  logic        vid_blocked;
  logic        grant_vid;
  logic        grant_cw;
  logic        grant_cr;
  logic        owner_strobe;
  logic [18:0] vid_ptr_sel;

  assign cache_pend  = c_wr_req | c_rd_req;
  assign vid_blocked = (streak_q == STREAK_MAX) && cache_pend;
  // Video wins unless its streak is spent while cache waits; it remains the
  // fallback when nothing else is asking.
  assign grant_vid   = (vid_low && !vid_blocked) || (vid_low && !cache_pend);
  assign grant_cw    = !grant_vid && c_wr_req;
  assign grant_cr    = !grant_vid && !c_wr_req && c_rd_req;

  assign vid_ptr_sel  = resync_q ? 19'd0 : ptr_q;
  assign owner_strobe = (owner_q == OWN_CW) ? sys_wr_data_valid : sys_rd_data_valid;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    ptr_d     = ptr_q;
    streak_d  = streak_q;
    resync_d  = resync_q;
    half_d    = half_q;
    low_d     = low_q;
    vq_data_d = vq_data_q;
    vq_we_d   = 1'b0;
    beat_d    = beat_q;

    case (state_q)
      S_IDLE: begin
        if (grant_vid) begin
          owner_d = OWN_VID;
          cmd_d   = CMD_RD32;
          addr_d  = {1'b1, vid_ptr_sel, 3'b000};
          if (resync_q) begin
            ptr_d    = 19'd0;
            resync_d = 1'b0;
          end
          if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
          end
          half_d  = 1'b0;
          state_d = S_CMD;
        end else if (grant_cw) begin
          owner_d  = OWN_CW;
          cmd_d    = CMD_WR;
          addr_d   = {c_waddr, 6'b0};
          streak_d = '0;
          state_d  = S_CMD;
        end else if (grant_cr) begin
          owner_d  = OWN_CR;
          cmd_d    = CMD_RD256;
          addr_d   = {c_raddr, 6'b0};
          streak_d = '0;
          state_d  = S_CMD;
        end
      end

      S_CMD: begin
        if (sys_cmd_ack == cmd_q) begin
          cmd_d   = CMD_NOP;
          beat_d  = (owner_q == OWN_VID) ? VID_LAST : LINE_LAST;
          if (owner_q == OWN_VID) begin
            ptr_d = (ptr_q == PTR_LAST) ? 19'd0 : ptr_q + 19'd1;
          end
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        if (owner_strobe) begin
          if (owner_q == OWN_VID) begin
            if (!half_q) begin
              low_d = sys_dout;
            end else begin
              vq_data_d = {sys_dout, low_q};
              vq_we_d   = 1'b1;
            end
            half_d = !half_q;
          end
          if (beat_q == '0) begin
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q - BEAT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A frame start seen together with a video grant stays pending for the next one.
    if (vid_sync) begin
      resync_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_VID;
      cmd_q     <= CMD_NOP;
      addr_q    <= '0;
      ptr_q     <= '0;
      streak_q  <= '0;
      resync_q  <= 1'b0;
      half_q    <= 1'b0;
      low_q     <= '0;
      vq_data_q <= '0;
      vq_we_q   <= 1'b0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      ptr_q     <= ptr_d;
      streak_q  <= streak_d;
      resync_q  <= resync_d;
      half_q    <= half_d;
      low_q     <= low_d;
      vq_data_q <= vq_data_d;
      vq_we_q   <= vq_we_d;
      beat_q    <= beat_d;
    end
  end

  assign sys_cmd       = cmd_q;
  assign sys_addr      = addr_q;
  assign vq_data       = vq_data_q;
  assign vq_we         = vq_we_q;
  assign busy          = (state_q != S_IDLE);
  assign cache_wr_data = (state_q == S_XFER) && (owner_q == OWN_CR) && sys_rd_data_valid;
  assign cache_rd_data = (state_q == S_XFER) && (owner_q == OWN_CW) && sys_wr_data_valid;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sdram_arbiter;

  localparam int VB  = 4;
  localparam int MS  = 4;
  localparam int VBE = 16;
  localparam int LBE = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_low, vid_sync, c_wr_req, c_rd_req;
  logic [16:0] c_waddr, c_raddr;
  logic [1:0]  sys_cmd, sys_cmd_ack;
  logic [22:0] sys_addr;
  logic        sys_rd_data_valid, sys_wr_data_valid;
  logic [15:0] sys_dout;
  logic        cache_wr_data, cache_rd_data;
  logic [31:0] vq_data;
  logic        vq_we, busy;

  sdram_arbiter #(
    .VID_BURSTS(VB), .MAX_VID_STREAK(MS), .VID_BEATS(VBE), .LINE_BEATS(LBE)
  ) dut (
    .clk(clk), .rst(rst), .vid_low(vid_low), .vid_sync(vid_sync),
    .c_wr_req(c_wr_req), .c_rd_req(c_rd_req), .c_waddr(c_waddr), .c_raddr(c_raddr),
    .sys_cmd(sys_cmd), .sys_addr(sys_addr), .sys_cmd_ack(sys_cmd_ack),
    .sys_rd_data_valid(sys_rd_data_valid), .sys_wr_data_valid(sys_wr_data_valid),
    .sys_dout(sys_dout), .cache_wr_data(cache_wr_data), .cache_rd_data(cache_rd_data),
    .vq_data(vq_data), .vq_we(vq_we), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time (phase 0 idle, 1 command, 2 data).
  bit          model_ready = 1'b0;
  int          m_phase, m_owner, m_ptr, m_streak, m_left, own;
  bit          m_resync, m_half, m_vqwe, cpend, strobe;
  logic [1:0]  m_cmd;
  logic [22:0] m_addr;
  logic [15:0] m_low;
  logic [31:0] m_vqd;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_owner = 0; m_ptr = 0; m_streak = 0; m_left = 0;
      m_resync = 0; m_half = 0; m_vqwe = 0; m_cmd = 0; m_addr = 0;
      m_low = 0; m_vqd = 0; model_ready = 1'b1;
    end else begin
      m_vqwe = 0;
      if (m_phase == 0) begin
        cpend = c_wr_req || c_rd_req;
        own = -1;
        if (vid_low && !(m_streak == MS && cpend)) own = 0;
        else if (c_wr_req) own = 1;
        else if (c_rd_req) own = 2;
        else if (vid_low) own = 0;
        if (own == 0) begin
          if (m_resync) begin m_ptr = 0; m_resync = 0; end
          m_cmd = 2'b10;
          m_addr = 23'h400000 + 23'(m_ptr * 8);
          m_streak = (m_streak < MS) ? m_streak + 1 : MS;
          m_half = 0;
        end else if (own == 1) begin
          m_cmd = 2'b01; m_addr = 23'(c_waddr) << 6; m_streak = 0;
        end else if (own == 2) begin
          m_cmd = 2'b11; m_addr = 23'(c_raddr) << 6; m_streak = 0;
        end
        if (own >= 0) begin m_owner = own; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (sys_cmd_ack == m_cmd) begin
          m_cmd = 2'b00;
          m_left = (m_owner == 0) ? VBE : LBE;
          if (m_owner == 0) m_ptr = (m_ptr + 1) % VB;
          m_phase = 2;
        end
      end else begin
        strobe = (m_owner == 1) ? sys_wr_data_valid : sys_rd_data_valid;
        if (strobe) begin
          if (m_owner == 0) begin
            if (!m_half) m_low = sys_dout;
            else begin m_vqd = {sys_dout, m_low}; m_vqwe = 1; end
            m_half = !m_half;
          end
          m_left--;
          if (m_left == 0) m_phase = 0;
        end
      end
      if (vid_sync) m_resync = 1;
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      chk("busy", busy, m_phase != 0);
      chk("sys_cmd", sys_cmd, m_cmd);
      chk("sys_addr", sys_addr, m_addr);
      chk("vq_we", vq_we, m_vqwe);
      chk("vq_data", vq_data, m_vqd);
      chk("cache_wr_data", cache_wr_data, m_phase == 2 && m_owner == 2 && sys_rd_data_valid);
      chk("cache_rd_data", cache_rd_data, m_phase == 2 && m_owner == 1 && sys_wr_data_valid);
    end
  end

  // Pulse counters and video word log for the literal checks.
  int          cnt_crd = 0;
  int          cnt_cwd = 0;
  bit          cap_en = 1'b0;
  logic [31:0] vq_log[$];

  always @(negedge clk) begin
    if (cache_rd_data) cnt_crd++;
    if (cache_wr_data) cnt_cwd++;
    if (cap_en && vq_we) vq_log.push_back(vq_data);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_cmd(output logic [1:0] cmd, output logic [22:0] addr);
    int n = 0;
    while (sys_cmd == 2'b00 && n < 300) begin tick; n++; end
    checks++;
    if (sys_cmd == 2'b00) begin
      errors++;
      $display("FAIL cmd_wait: no command after %0d cycles, required a grant", n);
    end
    cmd = sys_cmd;
    addr = sys_addr;
  endtask

  task automatic do_ack(input logic [1:0] cmd, input int delay, input bit noise);
    logic [1:0] v;
    repeat (delay) begin
      if (noise) begin
        v = 2'($urandom_range(0, 3));
        if (v == cmd) v = 2'b00;
        sys_cmd_ack = v;
        sys_rd_data_valid = ($urandom_range(0, 5) == 0);
        sys_wr_data_valid = ($urandom_range(0, 5) == 0);
        sys_dout = 16'($urandom);
      end
      tick;
    end
    sys_cmd_ack = cmd;
    sys_rd_data_valid = 1'b0;
    sys_wr_data_valid = 1'b0;
    tick;
    sys_cmd_ack = 2'b00;
  endtask

  task automatic do_beats(input int n, input bit wr, input int base, input bit noise);
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        repeat ($urandom_range(0, 2)) begin
          if (wr) sys_rd_data_valid = ($urandom_range(0, 2) == 0);
          else sys_wr_data_valid = ($urandom_range(0, 2) == 0);
          sys_dout = 16'($urandom);
          tick;
        end
      end
      if (wr) begin
        sys_wr_data_valid = 1'b1;
        sys_rd_data_valid = noise && ($urandom_range(0, 3) == 0);
      end else begin
        sys_rd_data_valid = 1'b1;
        sys_wr_data_valid = noise && ($urandom_range(0, 3) == 0);
      end
      sys_dout = 16'(base + i);
      tick;
      sys_rd_data_valid = 1'b0;
      sys_wr_data_valid = 1'b0;
    end
  endtask

  task automatic serve(input bit noise, input int ack_delay);
    logic [1:0]  cmd;
    logic [22:0] addr;
    wait_cmd(cmd, addr);
    if (cmd != 2'b00) begin
      do_ack(cmd, ack_delay, noise);
      do_beats((cmd == 2'b10) ? VBE : LBE, cmd == 2'b01, int'($urandom_range(0, 65535)), noise);
    end
  endtask

  bit rand_done = 1'b0;

  initial begin
    logic [1:0]  cmd;
    logic [22:0] addr;
    logic [22:0] vid_exp[5];
    logic [1:0]  seq_exp[10];
    int s0, s1, lo;

    rst = 1'b1; vid_low = 0; vid_sync = 0; c_wr_req = 0; c_rd_req = 0;
    c_waddr = 0; c_raddr = 0; sys_cmd_ack = 0; sys_rd_data_valid = 0;
    sys_wr_data_valid = 0; sys_dout = 0;
    repeat (3) tick;
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_cmd", sys_cmd, 0);
    chk("reset_addr", sys_addr, 0);
    chk("reset_vq", {vq_we, vq_data}, 0);
    tick;

    // Video only: pointer sequence 0,1,2,3,0 with packed words.
    vid_exp = '{23'h400000, 23'h400008, 23'h400010, 23'h400018, 23'h400000};
    cap_en = 1'b1;
    vid_low = 1'b1;
    for (int b = 0; b < 5; b++) begin
      wait_cmd(cmd, addr);
      if (b == 4) vid_low = 1'b0;
      chk("vid_cmd", cmd, 2'b10);
      chk("vid_addr", addr, vid_exp[b]);
      do_ack(cmd, 0, 0);
      do_beats(VBE, 0, b * 16, 0);
    end
    repeat (3) tick;
    cap_en = 1'b0;
    chk("vq_pulses", vq_log.size(), 40);
    for (int j = 0; j < vq_log.size() && j < 40; j++) begin
      lo = (j / 8) * 16 + 2 * (j % 8);
      chk("vq_word", vq_log[j], {16'(lo + 1), 16'(lo)});
    end

    // Write-back beats fill priority over a simultaneous fill.
    c_waddr = 17'h00012; c_raddr = 17'h00034;
    c_wr_req = 1'b1; c_rd_req = 1'b1;
    wait_cmd(cmd, addr);
    c_wr_req = 1'b0;
    chk("cw_cmd", cmd, 2'b01);
    chk("cw_addr", addr, 23'h000480);
    s0 = cnt_crd; s1 = cnt_cwd;
    do_ack(cmd, 2, 0);
    do_beats(LBE, 1, 0, 1);
    tick;
    chk("cw_mirror", cnt_crd - s0, 128);
    chk("cw_no_fill", cnt_cwd - s1, 0);
    wait_cmd(cmd, addr);
    c_rd_req = 1'b0;
    chk("cr_cmd", cmd, 2'b11);
    chk("cr_addr", addr, 23'h000D00);
    s0 = cnt_cwd;
    do_ack(cmd, 1, 0);
    do_beats(LBE, 0, 0, 1);
    tick;
    chk("cr_beats", cnt_cwd - s0, 128);

    // Video streak limit with a fill pending throughout.
    seq_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
    c_raddr = 17'h00055;
    vid_low = 1'b1; c_rd_req = 1'b1;
    for (int g = 0; g < 10; g++) begin
      wait_cmd(cmd, addr);
      if (g == 9) begin vid_low = 1'b0; c_rd_req = 1'b0; end
      chk("streak_seq", cmd, seq_exp[g]);
      if (seq_exp[g] == 2'b11) chk("streak_cr_addr", addr, 23'h001540);
      do_ack(cmd, int'($urandom_range(0, 3)), 1);
      do_beats((cmd == 2'b10) ? VBE : LBE, 0, g * 256, 1);
    end

    // Ack holds off, then mismatched, then matching.
    vid_low = 1'b1;
    wait_cmd(cmd, addr);
    vid_low = 1'b0;
    chk("hold_cmd0", cmd, 2'b10);
    chk("hold_addr0", addr, 23'h400008);
    repeat (20) tick;
    sys_cmd_ack = 2'b01;
    tick;
    sys_cmd_ack = 2'b00;
    chk("hold_cmd", sys_cmd, 2'b10);
    chk("hold_addr", sys_addr, 23'h400008);
    sys_cmd_ack = 2'b10;
    tick;
    sys_cmd_ack = 2'b00;
    chk("ack_to_nop", sys_cmd, 2'b00);
    do_beats(VBE, 0, 16'h0200, 0);

    // Frame resync restarts the pointer.
    tick;
    vid_sync = 1'b1;
    tick;
    vid_sync = 1'b0;
    vid_low = 1'b1;
    wait_cmd(cmd, addr);
    vid_low = 1'b0;
    chk("resync_addr", addr, 23'h400000);
    do_ack(cmd, 0, 0);
    do_beats(VBE, 0, 0, 0);
    vid_low = 1'b1;
    wait_cmd(cmd, addr);
    vid_low = 1'b0;
    chk("resync_next", addr, 23'h400008);
    do_ack(cmd, 0, 0);
    do_beats(VBE, 0, 0, 0);

    // Reset in the middle of a fill.
    c_raddr = 17'h1ABCD; c_rd_req = 1'b1;
    wait_cmd(cmd, addr);
    c_rd_req = 1'b0;
    chk("rst_cr_addr", addr, 23'h6AF340);
    do_ack(cmd, 3, 0);
    do_beats(60, 0, 0, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_cmd", sys_cmd, 0);
    s0 = cnt_cwd;
    do_beats(68, 0, 60, 0);
    tick;
    chk("rst_no_strobe", cnt_cwd - s0, 0);
    c_waddr = 17'h00001; c_wr_req = 1'b1;
    wait_cmd(cmd, addr);
    c_wr_req = 1'b0;
    chk("post_rst_cmd", cmd, 2'b01);
    chk("post_rst_addr", addr, 23'h000040);
    do_ack(cmd, 0, 0);
    do_beats(LBE, 1, 0, 0);

    // Randomized traffic against the model.
    fork
      begin
        while (!rand_done) begin
          vid_low  = ($urandom_range(0, 99) < 50);
          c_wr_req = ($urandom_range(0, 99) < 30);
          c_rd_req = ($urandom_range(0, 99) < 30);
          c_waddr  = 17'($urandom);
          c_raddr  = 17'($urandom);
          vid_sync = ($urandom_range(0, 39) == 0);
          tick;
        end
      end
      begin
        for (int t = 0; t < 30; t++) serve(1'b1, int'($urandom_range(0, 4)));
        rand_done = 1'b1;
      end
    join
    vid_low = 0; c_wr_req = 0; c_rd_req = 0; vid_sync = 0;
    repeat (5) tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
